// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: FSM state encodings, client ids and default widths.
// Imported by mem_arbiter and arb_pick2.
package mem_arbiter_pkg;

    localparam int unsigned AddrWDefault = 28;
    localparam int unsigned DataWDefault = 128;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StGntI    = 2'b01,
        StGntD    = 2'b10,
        StRelease = 2'b11
    } arb_state_e;

    typedef enum logic {
        ClientI = 1'b0,
        ClientD = 1'b1
    } client_e;

    function automatic client_e other_client(input client_e c);
        return (c == ClientI) ? ClientD : ClientI;
    endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way chooser between the I-cache and D-cache requests.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise the D-cache wins ties.
module arb_pick2 import mem_arbiter_pkg::*; (
    input  logic    req_i,
    input  logic    req_d,
    input  client_e rr_ptr,
    output logic    any_req,
    output client_e grant
);

    assign any_req = req_i | req_d;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        if (req_i && req_d) begin
            grant = rr_ptr;
        end else if (req_d) begin
            grant = ClientD;
        end else begin
            grant = ClientI;
        end
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;

    always_comb begin
        grant = req_d ? ClientD : ClientI;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache and D-cache miss ports and the single memory port.
// Tie-break policy is selected by ARB_ROUND_ROBIN_EN (default: fixed D-cache priority).
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              ic_read,
    input  logic              ic_write,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_wdata,
    output logic              ic_ready,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e state_q, state_d;
    logic       req_i, req_d, any_req;
    client_e    pick;
    client_e    rr_ptr;

    assign req_i = ic_read | ic_write;
    assign req_d = dc_read | dc_write;

`ifdef ARB_ROUND_ROBIN_EN
    client_e rr_q, rr_d;
    assign rr_ptr = rr_q;
`else
    assign rr_ptr = ClientI;
`endif

    arb_pick2 u_pick (
        .req_i   (req_i),
        .req_d   (req_d),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .grant   (pick)
    );

    always_comb begin
        state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d    = rr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = (pick == ClientD) ? StGntD : StGntI;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_d    = other_client(pick);
`endif
                end
            end
            // A dropped request before mem_ready is a protocol error: abandon silently.
            StGntI: begin
                if (mem_ready) begin
                    state_d = StRelease;
                end else if (!req_i) begin
                    state_d = StIdle;
                end
            end
            StGntD: begin
                if (mem_ready) begin
                    state_d = StRelease;
                end else if (!req_d) begin
                    state_d = StIdle;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state_q <= StIdle;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q    <= ClientI;
`endif
        end else begin
            state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Ready is masked during reset so an abandoned access never completes to a client.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ic_ready  = 1'b0;
        ic_rdata  = '0;
        dc_ready  = 1'b0;
        dc_rdata  = '0;
        case (state_q)
            StGntI: begin
                mem_write = ic_write;
                mem_read  = ic_read & ~ic_write;
                mem_addr  = ic_addr;
                mem_wdata = ic_wdata;
                ic_ready  = mem_ready & proc_reset_n;
                ic_rdata  = mem_rdata;
            end
            StGntD: begin
                mem_write = dc_write;
                mem_read  = dc_read & ~dc_write;
                mem_addr  = dc_addr;
                mem_wdata = dc_wdata;
                dc_ready  = mem_ready & proc_reset_n;
                dc_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

    a_ready_onehot: assert property (@(posedge clk) !(ic_ready && dc_ready));
    a_strobe_excl:  assert property (@(posedge clk) !(mem_read && mem_write));
    a_release_one:  assert property (@(posedge clk) disable iff (!proc_reset_n)
                                     (state_q == StRelease) |=> (state_q == StIdle));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expected values are hand-computed per vector.
module tb_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          proc_reset_n;
    logic          ic_read, ic_write, dc_read, dc_write;
    logic [AW-1:0] ic_addr, dc_addr, mem_addr;
    logic [DW-1:0] ic_wdata, dc_wdata, ic_rdata, dc_rdata, mem_wdata, mem_rdata;
    logic          ic_ready, dc_ready, mem_read, mem_write, mem_ready;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .ic_read      (ic_read),
        .ic_write     (ic_write),
        .ic_addr      (ic_addr),
        .ic_wdata     (ic_wdata),
        .ic_ready     (ic_ready),
        .ic_rdata     (ic_rdata),
        .dc_read      (dc_read),
        .dc_write     (dc_write),
        .dc_addr      (dc_addr),
        .dc_wdata     (dc_wdata),
        .dc_ready     (dc_ready),
        .dc_rdata     (dc_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic          first_d;
        logic [AW-1:0] a_first, a_second;

        proc_reset_n = 1'b0;
        ic_read = 1'b0; ic_write = 1'b0; ic_addr = '0; ic_wdata = '0;
        dc_read = 1'b0; dc_write = 1'b0; dc_addr = '0; dc_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        cyc();
        cyc();
        check("rst_mem_read", 128'(mem_read), 128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        check("rst_ic_ready", 128'(ic_ready), 128'd0);
        check("rst_dc_ready", 128'(dc_ready), 128'd0);
        proc_reset_n = 1'b1;
        cyc();

        // 1: lone I-cache read, memory ready on the 4th grant cycle
        ic_read = 1'b1; ic_addr = 28'h0000010; #1;
        check("t1_idle_no_strobe", 128'(mem_read), 128'd0);
        cyc();
        check("t1_mem_read", 128'(mem_read), 128'd1);
        check("t1_mem_addr", 128'(mem_addr), 128'h10);
        check("t1_no_early_ready", 128'(ic_ready), 128'd0);
        cyc();
        cyc();
        cyc();
        mem_ready = 1'b1; mem_rdata = {16{8'hA5}}; #1;
        check("t1_ic_ready", 128'(ic_ready), 128'd1);
        check("t1_ic_rdata", ic_rdata, {16{8'hA5}});
        check("t1_dc_ready", 128'(dc_ready), 128'd0);
        check("t1_dc_rdata", dc_rdata, 128'd0);
        cyc();
        ic_read = 1'b0; mem_ready = 1'b0; #1;
        check("t1_release_ready", 128'(ic_ready), 128'd0);
        check("t1_release_strobe", 128'(mem_read), 128'd0);
        cyc();

        // 2: D-cache writeback, then allocate read issued during RELEASE
        dc_write = 1'b1; dc_addr = 28'h0000123; dc_wdata = {4{32'hDEADBEEF}}; #1;
        cyc();
        check("t2_wb_write", 128'(mem_write), 128'd1);
        check("t2_wb_read", 128'(mem_read), 128'd0);
        check("t2_wb_addr", 128'(mem_addr), 128'h123);
        check("t2_wb_wdata", mem_wdata, {4{32'hDEADBEEF}});
        mem_ready = 1'b1; #1;
        check("t2_wb_ready", 128'(dc_ready), 128'd1);
        cyc();
        mem_ready = 1'b0; dc_write = 1'b0; dc_read = 1'b1; dc_addr = 28'h0000456; #1;
        check("t2_release_strobe", 128'(mem_read | mem_write), 128'd0);
        cyc();
        check("t2_idle_gap", 128'(mem_read), 128'd0);
        cyc();
        check("t2_alloc_read", 128'(mem_read), 128'd1);
        check("t2_alloc_addr", 128'(mem_addr), 128'h456);
        mem_ready = 1'b1; mem_rdata = 128'h0123456789ABCDEF_FEDCBA9876543210; #1;
        check("t2_alloc_rdata", dc_rdata, 128'h0123456789ABCDEF_FEDCBA9876543210);
        cyc();
        mem_ready = 1'b0; dc_read = 1'b0;
        cyc();

        // 3: simultaneous requests over 4 pairs, starting from reset
        proc_reset_n = 1'b0;
        cyc();
        proc_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ic_read = 1'b1; ic_addr = AW'(32'h100 + k);
            dc_read = 1'b1; dc_addr = AW'(32'h200 + k);
            first_d  = ~RrEn;
            a_first  = first_d ? AW'(32'h200 + k) : AW'(32'h100 + k);
            a_second = first_d ? AW'(32'h100 + k) : AW'(32'h200 + k);
            #1;
            cyc();
            check($sformatf("t3_first_addr_%0d", k), 128'(mem_addr), 128'(a_first));
            mem_ready = 1'b1; #1;
            check($sformatf("t3_first_ready_%0d", k),
                  128'(first_d ? dc_ready : ic_ready), 128'd1);
            check($sformatf("t3_pending_no_ready_%0d", k),
                  128'(first_d ? ic_ready : dc_ready), 128'd0);
            cyc();
            mem_ready = 1'b0;
            if (first_d) dc_read = 1'b0;
            else ic_read = 1'b0;
            cyc();
            cyc();
            check($sformatf("t3_second_addr_%0d", k), 128'(mem_addr), 128'(a_second));
            mem_ready = 1'b1; #1;
            check($sformatf("t3_second_ready_%0d", k),
                  128'(first_d ? ic_ready : dc_ready), 128'd1);
            cyc();
            mem_ready = 1'b0; ic_read = 1'b0; dc_read = 1'b0;
            cyc();
        end

        // 4: mem_ready held for two cycles, I-cache asks during RELEASE
        dc_read = 1'b1; dc_addr = 28'h0000321; #1;
        cyc();
        mem_ready = 1'b1; #1;
        check("t4_dc_ready", 128'(dc_ready), 128'd1);
        cyc();
        dc_read = 1'b0; ic_read = 1'b1; ic_addr = 28'h0000055; #1;
        check("t4_release_dc_ready", 128'(dc_ready), 128'd0);
        check("t4_release_ic_ready", 128'(ic_ready), 128'd0);
        check("t4_release_no_grant", 128'(mem_read), 128'd0);
        cyc();
        mem_ready = 1'b0; #1;
        check("t4_idle_no_grant", 128'(mem_read), 128'd0);
        cyc();
        check("t4_ic_granted", 128'(mem_addr), 128'h55);
        mem_ready = 1'b1; #1;
        cyc();
        mem_ready = 1'b0; ic_read = 1'b0;
        cyc();

        // 5: reset during GNT_D with an I-cache read pending
        dc_read = 1'b1; dc_addr = 28'h0000777; #1;
        cyc();
        ic_read = 1'b1; ic_addr = 28'h00000AB; #1;
        check("t5_gnt_d_addr", 128'(mem_addr), 128'h777);
        proc_reset_n = 1'b0; mem_ready = 1'b1; #1;
        check("t5_rst_no_dc_ready", 128'(dc_ready), 128'd0);
        cyc();
        proc_reset_n = 1'b1; dc_read = 1'b0; mem_ready = 1'b0; #1;
        check("t5_after_rst_read", 128'(mem_read), 128'd0);
        check("t5_after_rst_addr", 128'(mem_addr), 128'd0);
        check("t5_after_rst_dc_ready", 128'(dc_ready), 128'd0);
        cyc();
        check("t5_ic_granted_read", 128'(mem_read), 128'd1);
        check("t5_ic_granted_addr", 128'(mem_addr), 128'hAB);
        mem_ready = 1'b1; mem_rdata = 128'h5A; #1;
        check("t5_ic_ready", 128'(ic_ready), 128'd1);
        cyc();
        mem_ready = 1'b0; ic_read = 1'b0;
        cyc();

        // 6: read and write both set, write wins
        dc_read = 1'b1; dc_write = 1'b1; dc_addr = 28'h00000CC; dc_wdata = 128'hC0FFEE; #1;
        cyc();
        check("t6_mem_write", 128'(mem_write), 128'd1);
        check("t6_mem_read", 128'(mem_read), 128'd0);
        check("t6_mem_wdata", mem_wdata, 128'hC0FFEE);
        mem_ready = 1'b1; #1;
        cyc();
        mem_ready = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
